// File: rtl/slave_port_adapter.sv
// slave_port_adapter: per-master AXI4 crossbar port that decodes addresses, slices requests onto the arbitrated buses and returns R/B; DECERR_RESP_EN adds local decode-error responses
module slave_port_adapter #(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int WIDTH      = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LOG_N      = (N > 1) ? $clog2(N) : 1,
  parameter int LOG_M      = (M > 1) ? $clog2(M) : 1,
  parameter int PORT_IDX   = 0,
  parameter int SEL_LSB    = 28,
  parameter int WQ_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [WIDTH-1:0]      s_axi_wdata,
  input  logic [WIDTH/8-1:0]    s_axi_wstrb,
  input  logic                  s_axi_wlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  busARVld_o,
  input  logic                  busARRdy_i,
  output logic [ADDR_WIDTH-1:0] busARAddr_o,
  output logic [ID_WIDTH-1:0]   busARId_o,
  output logic [7:0]            busARLen_o,
  output logic [2:0]            busARSz_o,
  output logic [1:0]            busARBurst_o,
  output logic [LOG_N-1:0]      busARSrc_o,
  output logic [LOG_M-1:0]      busARDst_o,
  output logic                  busAWVld_o,
  input  logic                  busAWRdy_i,
  output logic [ADDR_WIDTH-1:0] busAWAddr_o,
  output logic [ID_WIDTH-1:0]   busAWId_o,
  output logic [7:0]            busAWLen_o,
  output logic [2:0]            busAWSz_o,
  output logic [1:0]            busAWBurst_o,
  output logic [LOG_N-1:0]      busAWSrc_o,
  output logic [LOG_M-1:0]      busAWDst_o,
  output logic                  busWVld_o,
  input  logic                  busWRdy_i,
  output logic [WIDTH-1:0]      busWData_o,
  output logic [WIDTH/8-1:0]    busWStrb_o,
  output logic                  busWLast_o,
  output logic [LOG_N-1:0]      busWSrc_o,
  output logic [LOG_M-1:0]      busWDst_o,
  input  logic                  busRVld_i,
  output logic                  busRRdy_o,
  input  logic [WIDTH-1:0]      busRData_i,
  input  logic [ID_WIDTH-1:0]   busRId_i,
  input  logic [1:0]            busRResp_i,
  input  logic                  busRLast_i,
  input  logic                  busBVld_i,
  output logic                  busBRdy_o,
  input  logic [ID_WIDTH-1:0]   busBId_i,
  input  logic [1:0]            busBResp_i
);
  localparam int LQ = $clog2(WQ_DEPTH);
  logic ar_full, aw_full, w_full, ar_hs, aw_hs, w_hs, ar_err, aw_err;
  logic head_err, wq_full, wq_empty, wq_pop, r_busy, b_busy;
  logic [LOG_M-1:0] ar_dst, aw_dst;
  logic [LQ:0] wq_cnt;
  logic [LQ-1:0] wq_wp, wq_rp;
  logic [LOG_M:0] wq_mem [WQ_DEPTH];
  logic [7:0] r_cnt;
  logic [ID_WIDTH-1:0] r_id, b_id;
  assign ar_dst = s_axi_araddr[SEL_LSB +: LOG_M];
  assign aw_dst = s_axi_awaddr[SEL_LSB +: LOG_M];
  assign wq_full = wq_cnt == (LQ+1)'(WQ_DEPTH);
  assign wq_empty = wq_cnt == '0;
  assign head_err = wq_mem[wq_rp][LOG_M];
  assign s_axi_arready = !ar_full && !r_busy;
  assign s_axi_awready = !aw_full && !wq_full;
  assign s_axi_wready = !wq_empty && (head_err ? !b_busy : !w_full);
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign wq_pop = (w_full && busWRdy_i && busWLast_o) || (w_hs && head_err && s_axi_wlast);
  assign busARVld_o = ar_full;
  assign busAWVld_o = aw_full;
  assign busWVld_o = w_full;
  assign busARSrc_o = LOG_N'(PORT_IDX);
  assign busAWSrc_o = LOG_N'(PORT_IDX);
  assign busWSrc_o = LOG_N'(PORT_IDX);
  assign busWDst_o = wq_mem[wq_rp][LOG_M-1:0];
  assign s_axi_rvalid = r_busy ? 1'b1 : busRVld_i;
  assign s_axi_rid = r_busy ? r_id : busRId_i;
  assign s_axi_rdata = r_busy ? '0 : busRData_i;
  assign s_axi_rresp = r_busy ? 2'b11 : busRResp_i;
  assign s_axi_rlast = r_busy ? r_cnt == 8'd0 : busRLast_i;
  assign busRRdy_o = !r_busy && s_axi_rready;
  assign s_axi_bvalid = b_busy ? 1'b1 : busBVld_i;
  assign s_axi_bid = b_busy ? b_id : busBId_i;
  assign s_axi_bresp = b_busy ? 2'b11 : busBResp_i;
  assign busBRdy_o = !b_busy && s_axi_bready;
  // AR slice: one entry, refilled only after the bus has taken the previous request
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_full <= 1'b0;
      busARAddr_o <= '0;
      busARId_o <= '0;
      busARLen_o <= '0;
      busARSz_o <= '0;
      busARBurst_o <= '0;
      busARDst_o <= '0;
    end else if (ar_hs && !ar_err) begin
      ar_full <= 1'b1;
      busARAddr_o <= s_axi_araddr;
      busARId_o <= s_axi_arid;
      busARLen_o <= s_axi_arlen;
      busARSz_o <= s_axi_arsize;
      busARBurst_o <= s_axi_arburst;
      busARDst_o <= ar_dst;
    end else if (busARRdy_i) ar_full <= 1'b0;
  end
  // AW slice: same shape as AR; decode errors never occupy the slice
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full <= 1'b0;
      busAWAddr_o <= '0;
      busAWId_o <= '0;
      busAWLen_o <= '0;
      busAWSz_o <= '0;
      busAWBurst_o <= '0;
      busAWDst_o <= '0;
    end else if (aw_hs && !aw_err) begin
      aw_full <= 1'b1;
      busAWAddr_o <= s_axi_awaddr;
      busAWId_o <= s_axi_awid;
      busAWLen_o <= s_axi_awlen;
      busAWSz_o <= s_axi_awsize;
      busAWBurst_o <= s_axi_awburst;
      busAWDst_o <= aw_dst;
    end else if (busAWRdy_i) aw_full <= 1'b0;
  end
  // W slice: beats for errored bursts are swallowed instead of captured
  always_ff @(posedge clk) begin
    if (rst) begin
      w_full <= 1'b0;
      busWData_o <= '0;
      busWStrb_o <= '0;
      busWLast_o <= 1'b0;
    end else if (w_hs && !head_err) begin
      w_full <= 1'b1;
      busWData_o <= s_axi_wdata;
      busWStrb_o <= s_axi_wstrb;
      busWLast_o <= s_axi_wlast;
    end else if (busWRdy_i) w_full <= 1'b0;
  end
  // W-destination queue: one {err,dst} per accepted AW, retired when its last beat leaves
  always_ff @(posedge clk) begin
    if (rst) begin
      wq_cnt <= '0;
      wq_wp <= '0;
      wq_rp <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        wq_mem[wq_wp] <= {aw_err, aw_dst};
        wq_wp <= wq_wp + LQ'(1);
      end
      if (wq_pop) wq_rp <= wq_rp + LQ'(1);
      wq_cnt <= wq_cnt + (LQ+1)'(aw_hs) - (LQ+1)'(wq_pop);
    end
  end
`ifdef DECERR_RESP_EN
  typedef enum logic {R_IDLE, R_ERR} r_state_t;
  typedef enum logic {B_IDLE, B_ERR} b_state_t;
  r_state_t r_st;
  b_state_t b_st;
  logic [ID_WIDTH-1:0] wq_id [WQ_DEPTH];
  assign ar_err = {1'b0, ar_dst} >= (LOG_M+1)'(M);
  assign aw_err = {1'b0, aw_dst} >= (LOG_M+1)'(M);
  assign r_busy = r_st == R_ERR;
  assign b_busy = b_st == B_ERR;
  // Read decode-error FSM: plays out arlen+1 local error beats
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= R_IDLE;
      r_cnt <= '0;
      r_id <= '0;
    end else if (r_st == R_IDLE) begin
      if (ar_hs && ar_err) begin
        r_st <= R_ERR;
        r_cnt <= s_axi_arlen;
        r_id <= s_axi_arid;
      end
    end else if (s_axi_rready) begin
      r_cnt <= r_cnt - 8'd1;
      if (r_cnt == 8'd0) r_st <= R_IDLE;
    end
  end
  // Write decode-error FSM: issues the local B once the absorbed burst ends
  always_ff @(posedge clk) begin
    if (rst) begin
      b_st <= B_IDLE;
      b_id <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_id[i] <= '0;
    end else begin
      if (aw_hs) wq_id[wq_wp] <= s_axi_awid;
      if (b_st == B_IDLE && w_hs && head_err && s_axi_wlast) begin
        b_st <= B_ERR;
        b_id <= wq_id[wq_rp];
      end else if (b_st == B_ERR && s_axi_bready) b_st <= B_IDLE;
    end
  end
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
  assign r_busy = 1'b0;
  assign b_busy = 1'b0;
  assign r_cnt = '0;
  assign r_id = '0;
  assign b_id = '0;
`endif
endmodule

// File: tb/tb_slave_port_adapter.sv
// tb_slave_port_adapter: directed scoreboard bench for slave_port_adapter
module tb_slave_port_adapter;
`ifdef DECERR_RESP_EN
  localparam int M_P = 3;
`else
  localparam int M_P = 2;
`endif
  localparam int LM = (M_P > 1) ? $clog2(M_P) : 1;
  logic clk, rst;
  logic s_axi_arvalid, s_axi_arready, s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [3:0] s_axi_arid, s_axi_awid, s_axi_rid, s_axi_bid;
  logic [31:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata, s_axi_rdata;
  logic [7:0] s_axi_arlen, s_axi_awlen;
  logic [2:0] s_axi_arsize, s_axi_awsize;
  logic [1:0] s_axi_arburst, s_axi_awburst, s_axi_rresp, s_axi_bresp;
  logic [3:0] s_axi_wstrb;
  logic s_axi_rvalid, s_axi_rready, s_axi_rlast, s_axi_bvalid, s_axi_bready;
  logic busARVld_o, busARRdy_i, busAWVld_o, busAWRdy_i, busWVld_o, busWRdy_i, busWLast_o;
  logic [31:0] busARAddr_o, busAWAddr_o, busWData_o, busRData_i;
  logic [3:0] busARId_o, busAWId_o, busWStrb_o, busRId_i, busBId_i;
  logic [7:0] busARLen_o, busAWLen_o;
  logic [2:0] busARSz_o, busAWSz_o;
  logic [1:0] busARBurst_o, busAWBurst_o, busRResp_i, busBResp_i;
  logic busARSrc_o, busAWSrc_o, busWSrc_o;
  logic [LM-1:0] busARDst_o, busAWDst_o, busWDst_o;
  logic busRVld_i, busRRdy_o, busRLast_i, busBVld_i, busBRdy_o;
  int n_pass = 0, n_chk = 0, n_fail = 0;
  logic [127:0] ar_q[$], aw_q[$], w_q[$];
  logic [127:0] e_ar, e_aw, e_w;
  int dq[$];

  slave_port_adapter #(.N(2), .M(M_P), .PORT_IDX(1)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .busARVld_o(busARVld_o), .busARRdy_i(busARRdy_i), .busARAddr_o(busARAddr_o), .busARId_o(busARId_o),
    .busARLen_o(busARLen_o), .busARSz_o(busARSz_o), .busARBurst_o(busARBurst_o), .busARSrc_o(busARSrc_o), .busARDst_o(busARDst_o),
    .busAWVld_o(busAWVld_o), .busAWRdy_i(busAWRdy_i), .busAWAddr_o(busAWAddr_o), .busAWId_o(busAWId_o),
    .busAWLen_o(busAWLen_o), .busAWSz_o(busAWSz_o), .busAWBurst_o(busAWBurst_o), .busAWSrc_o(busAWSrc_o), .busAWDst_o(busAWDst_o),
    .busWVld_o(busWVld_o), .busWRdy_i(busWRdy_i), .busWData_o(busWData_o), .busWStrb_o(busWStrb_o),
    .busWLast_o(busWLast_o), .busWSrc_o(busWSrc_o), .busWDst_o(busWDst_o),
    .busRVld_i(busRVld_i), .busRRdy_o(busRRdy_o), .busRData_i(busRData_i), .busRId_i(busRId_i),
    .busRResp_i(busRResp_i), .busRLast_i(busRLast_i),
    .busBVld_i(busBVld_i), .busBRdy_o(busBRdy_o), .busBId_i(busBId_i), .busBResp_i(busBResp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  function automatic logic [127:0] a_vec(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input int dst);
    return 128'({a, id, len, 3'd2, 2'd1, 1'b1, LM'(dst)});
  endfunction

  function automatic logic [127:0] w_vec(input logic [31:0] d, input logic [3:0] s, input logic l, input int dst);
    return 128'({d, s, l, 1'b1, LM'(dst)});
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ar_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input int dst, input bit bus);
    int b = 0;
    s_axi_araddr = a; s_axi_arid = id; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && b < 50) begin @(negedge clk); b++; end
    chk1("ar_accept", s_axi_arready, 1'b1);
    if (bus) ar_q.push_back(a_vec(a, id, len, dst));
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
  endtask

  task automatic aw_go(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len, input int dst, input bit bus);
    int b = 0;
    s_axi_awaddr = a; s_axi_awid = id; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && b < 50) begin @(negedge clk); b++; end
    chk1("aw_accept", s_axi_awready, 1'b1);
    if (bus) aw_q.push_back(a_vec(a, id, len, dst));
    dq.push_back(bus ? dst : -1);
    @(posedge clk); #1 s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic l);
    int b = 0;
    int dst;
    s_axi_wdata = d; s_axi_wstrb = d[3:0]; s_axi_wlast = l; s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && b < 50) begin @(negedge clk); b++; end
    chk1("w_accept", s_axi_wready, 1'b1);
    dst = dq.size() != 0 ? dq[0] : -1;
    if (dst >= 0) w_q.push_back(w_vec(d, d[3:0], l, dst));
    if (l && dq.size() != 0) void'(dq.pop_front());
    @(posedge clk); #1 s_axi_wvalid = 1'b0;
  endtask

  // bus-side monitors: every bus handshake must match the oldest expected request
  always @(negedge clk) begin
    if (!rst) begin
      if (busARVld_o && busARRdy_i) begin
        e_ar = 'x;
        if (ar_q.size() != 0) e_ar = ar_q.pop_front();
        chk("bus_ar", 128'({busARAddr_o, busARId_o, busARLen_o, busARSz_o, busARBurst_o, busARSrc_o, busARDst_o}), e_ar);
      end
      if (busAWVld_o && busAWRdy_i) begin
        e_aw = 'x;
        if (aw_q.size() != 0) e_aw = aw_q.pop_front();
        chk("bus_aw", 128'({busAWAddr_o, busAWId_o, busAWLen_o, busAWSz_o, busAWBurst_o, busAWSrc_o, busAWDst_o}), e_aw);
      end
      if (busWVld_o && busWRdy_i) begin
        e_w = 'x;
        if (w_q.size() != 0) e_w = w_q.pop_front();
        chk("bus_w", 128'({busWData_o, busWStrb_o, busWLast_o, busWSrc_o, busWDst_o}), e_w);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {s_axi_arvalid, s_axi_awvalid, s_axi_wvalid, s_axi_wlast, s_axi_rready, s_axi_bready} = '0;
    {s_axi_arid, s_axi_awid, s_axi_araddr, s_axi_awaddr, s_axi_arlen, s_axi_awlen} = '0;
    s_axi_arsize = 3'd2; s_axi_awsize = 3'd2; s_axi_arburst = 2'd1; s_axi_awburst = 2'd1;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    {busARRdy_i, busAWRdy_i, busWRdy_i, busRVld_i, busRLast_i, busBVld_i} = '0;
    busRData_i = '0; busRId_i = '0; busRResp_i = '0; busBId_i = '0; busBResp_i = '0;
    cyc(2);
    @(negedge clk);
    chk1("rst_arready", s_axi_arready, 1'b1);
    chk1("rst_awready", s_axi_awready, 1'b1);
    chk1("rst_wready", s_axi_wready, 1'b0);
    chk1("rst_ar_vld", busARVld_o, 1'b0);
    chk1("rst_aw_vld", busAWVld_o, 1'b0);
    chk1("rst_w_vld", busWVld_o, 1'b0);
    chk1("rst_rvalid", s_axi_rvalid, 1'b0);
    chk1("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_fields", 128'({busARAddr_o, busAWAddr_o, busWData_o, busWDst_o}), 128'(0));
    cyc(1);
    rst = 1'b0;
    cyc(1);
    // AR: one-cycle latency, held under backpressure, then taken
    ar_go(32'h1000_0000, 4'h5, 8'd3, 1, 1'b1);
    @(negedge clk);
    chk1("ar_latency", busARVld_o, 1'b1);
    chk1("ar_busy_no_accept", s_axi_arready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ar_hold", 128'({busARVld_o, busARAddr_o, busARDst_o}), 128'({1'b1, 32'h1000_0000, LM'(1)}));
    end
    cyc(1);
    busARRdy_i = 1'b1;
    cyc(1);
    busARRdy_i = 1'b0;
    @(negedge clk);
    chk1("ar_cleared", busARVld_o, 1'b0);
    cyc(1);
    // W offered ahead of its AW, then a 4-beat burst to dst 0
    busAWRdy_i = 1'b1; busWRdy_i = 1'b1;
    s_axi_wdata = 32'hA0; s_axi_wvalid = 1'b1;
    @(negedge clk);
    chk1("w_before_aw", s_axi_wready, 1'b0);
    @(negedge clk);
    chk1("w_before_aw2", s_axi_wready, 1'b0);
    cyc(1);
    aw_go(32'h0000_0100, 4'h2, 8'd3, 0, 1'b1);
    for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), i == 3);
    cyc(1);
    @(negedge clk);
    chk1("wq_empty_after_burst", s_axi_wready, 1'b0);
    cyc(1);
    // Fill the W queue, check AW stall, then free one slot
    aw_go(32'h0000_0000, 4'h1, 8'd0, 0, 1'b1);
    aw_go(32'h1000_0000, 4'h2, 8'd0, 1, 1'b1);
    aw_go(32'h0000_0200, 4'h3, 8'd0, 0, 1'b1);
    aw_go(32'h1000_0300, 4'h4, 8'd0, 1, 1'b1);
    cyc(1);
    s_axi_awaddr = 32'h0000_0400; s_axi_awvalid = 1'b1;
    @(negedge clk);
    chk1("wq_full_awready", s_axi_awready, 1'b0);
    cyc(1);
    @(negedge clk);
    chk1("wq_full_awready2", s_axi_awready, 1'b0);
    cyc(1);
    s_axi_awvalid = 1'b0;
    w_beat(32'hB0, 1'b1);
    cyc(1);
    @(negedge clk);
    chk1("wq_slot_freed", s_axi_awready, 1'b1);
    cyc(1);
    for (int i = 1; i < 4; i++) w_beat(32'hB0 + 32'(i), 1'b1);
    cyc(2);
    // R/B pass-through with zero latency
    busRVld_i = 1'b1; busRId_i = 4'h3; busRData_i = 32'hCAFE_F00D; busRResp_i = 2'b01; busRLast_i = 1'b1; s_axi_rready = 1'b0;
    #1;
    chk("r_pass", 128'({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 128'({1'b1, 4'h3, 32'hCAFE_F00D, 2'b01, 1'b1}));
    chk1("r_rdy_low", busRRdy_o, 1'b0);
    s_axi_rready = 1'b1;
    #1;
    chk1("r_rdy_high", busRRdy_o, 1'b1);
    busRVld_i = 1'b0;
    busBVld_i = 1'b1; busBId_i = 4'hA; busBResp_i = 2'b10; s_axi_bready = 1'b0;
    #1;
    chk("b_pass", 128'({s_axi_bvalid, s_axi_bid, s_axi_bresp, busBRdy_o}), 128'({1'b1, 4'hA, 2'b10, 1'b0}));
    s_axi_bready = 1'b1;
    #1;
    chk1("b_rdy_high", busBRdy_o, 1'b1);
    busBVld_i = 1'b0; s_axi_bready = 1'b0;
    cyc(1);
`ifdef DECERR_RESP_EN
    // Decode-error read: 3 local beats, nothing on the bus
    s_axi_rready = 1'b1;
    ar_go(32'h3000_0000, 4'h6, 8'd2, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("derr_r_beat", 128'({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 128'({1'b1, 4'h6, 32'h0, 2'b11, i == 2}));
      chk("derr_r_block", 128'({s_axi_arready, busRRdy_o, busARVld_o}), 128'(0));
    end
    @(negedge clk);
    chk("derr_r_done", 128'({s_axi_rvalid, s_axi_arready}), 128'({1'b0, 1'b1}));
    cyc(1);
    // Decode-error write: burst absorbed, local B
    aw_go(32'h3000_0000, 4'h9, 8'd1, 3, 1'b0);
    w_beat(32'hD0, 1'b0);
    w_beat(32'hD1, 1'b1);
    @(negedge clk);
    chk("derr_b", 128'({s_axi_bvalid, s_axi_bid, s_axi_bresp, busWVld_o}), 128'({1'b1, 4'h9, 2'b11, 1'b0}));
    cyc(1);
    s_axi_bready = 1'b1;
    @(negedge clk);
    chk("derr_b_rdy", 128'({s_axi_bvalid, busBRdy_o}), 128'({1'b1, 1'b0}));
    cyc(1);
    @(negedge clk);
    chk("derr_b_done", 128'({s_axi_bvalid, busBRdy_o}), 128'({1'b0, 1'b1}));
    cyc(1);
    s_axi_bready = 1'b0;
`endif
    // Reset in the middle of a W burst
    aw_go(32'h1000_0040, 4'h4, 8'd3, 1, 1'b1);
    w_beat(32'hC0, 1'b0);
    w_beat(32'hC1, 1'b0);
    cyc(1);
    s_axi_wdata = 32'hC2; s_axi_wvalid = 1'b1; rst = 1'b1;
    cyc(1);
    @(negedge clk);
    dq.delete();
    chk("midrst_ready", 128'({s_axi_arready, s_axi_awready, s_axi_wready}), 128'(3'b110));
    chk("midrst_vld", 128'({busARVld_o, busAWVld_o, busWVld_o}), 128'(0));
    chk("midrst_fields", 128'({busWData_o, busWDst_o, busAWAddr_o}), 128'(0));
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst_q_empty", s_axi_wready, 1'b0);
    cyc(1);
    @(negedge clk);
    chk("midrst_q_empty2", 128'({s_axi_wready, busWVld_o}), 128'(0));
    cyc(1);
    s_axi_wvalid = 1'b0;
    cyc(2);
    chk("scoreboards_drained", 128'(ar_q.size() + aw_q.size() + w_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/slave_port_adapter.md
# slave_port_adapter

- Per-master ingress/egress port of the AXI4 switch. Placed once per master, N instances total.
- Request side: accepts AR/AW/W from one upstream master and decodes each address to a slave index. Presents the requests on the arbitrated AR/AW/W buses tagged with source and destination.
- Response side: returns R/B beats from the arbitrated response buses to the master.
- Sits opposite the slave-side switch; together they form the full crossbar.

## Interface
Parameters:
- N, 2, number of masters
- M, 2, number of slaves
- WIDTH, 32, data width
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, address width
- LOG_N, $clog2(N) (1 if N=1), source index width
- LOG_M, $clog2(M) (1 if M=1), destination index width
- PORT_IDX, 0, this port's master index, driven on every Src field
- SEL_LSB, 28, lowest address bit of the slave-select field; dst = addr[SEL_LSB +: LOG_M]
- WQ_DEPTH, 4, depth of the AW-destination queue (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_axi_ar{valid,ready,id,addr,len,size,burst}  in/out/in…  AXI AR from master (ready is an output)
- s_axi_aw{valid,ready,id,addr,len,size,burst}  as AR  AXI AW from master
- s_axi_w{valid,ready,data,strb,last}  in/out/in  AXI W from master
- s_axi_r{valid,ready,id,data,resp,last}  out/in/out  AXI R to master
- s_axi_b{valid,ready,id,resp}  out/in/out  AXI B to master
- busARVld_o/busARRdy_i, busARAddr_o, busARId_o, busARLen_o, busARSz_o, busARBurst_o, busARSrc_o[LOG_N], busARDst_o[LOG_M]  arbitrated AR bus
- busAW* (same set as AR)  arbitrated AW bus
- busWVld_o/busWRdy_i, busWData_o, busWStrb_o, busWLast_o, busWSrc_o, busWDst_o  arbitrated W bus
- busRVld_i/busRRdy_o, busRData_i, busRId_i, busRResp_i, busRLast_i  R bus, already qualified for this port
- busBVld_i/busBRdy_o, busBId_i, busBResp_i  B bus, already qualified for this port

## Operation
- AR slice:
  - One-entry register. s_axi_arready = !ar_full.
  - On a master handshake, captures fields and dst, and sets ar_full.
  - busARVld_o = ar_full. Clears on busARRdy_i.
- AW slice:
  - Same structure as AR. awready = !aw_full && !wq_full.
  - On a master handshake, pushes {err, dst} into the W-destination queue.
- W path:
  - s_axi_wready = !w_full && !wq_empty. W beats never precede their AW.
  - A beat is captured into a one-entry slice with busWDst_o = queue head dst.
  - The queue pops on the bus handshake (busWVld_o && busWRdy_i) of a beat with last = 1.
- R/B return:
  - Combinational pass-through: s_axi_r* = busR*, busRRdy_o = s_axi_rready. B is the same.
- Src fields are the constant PORT_IDX.
- Simultaneous push and pop on the queue is allowed and leaves the count unchanged.
- Queue pointers wrap modulo WQ_DEPTH.

## Timing
- Request latency: master handshake at cycle t -> bus valid at t+1. The bus valid holds with stable fields until the bus ready.
- Slice throughput: one transfer per 2 cycles. A new request is not accepted in the same cycle as the bus ready.
- R/B latency: 0 cycles.
- Reset (rst sampled high at a clk edge):
  - All slices are empty and the queue is empty.
  - Decerr FSMs go to IDLE.
  - Output values:
    - busARVld_o=busAWVld_o=busWVld_o=0
    - s_axi_rvalid=s_axi_bvalid=0
    - s_axi_arready=s_axi_awready=1
    - s_axi_wready=0
    - All data/field outputs=0
- Reset in mid-burst drops all state; no partial transfers resume.
- queue full -> awready=0; queue empty -> wready=0.

## Configuration
- Macro: DECERR_RESP_EN.
- With the macro defined, a dst >= M is a decode error.
- Decode-error read:
  - Never reaches the bus.
  - FSM R_IDLE->R_ERR drives arlen+1 local R beats: rid = arid, rdata = 0, rresp = 2'b11, rlast on the final beat.
  - busRRdy_o = 0 and arready = 0 while in R_ERR.
  - The FSM returns to R_IDLE after the last beat handshake.
- Decode-error write:
  - The queue entry has err = 1. Its W beats are absorbed locally (wready follows queue state, no bus valid).
  - After wlast, a local B is issued with bid = awid, bresp = 2'b11. busBRdy_o = 0 until the local B handshake.
- Without the macro: dst = truncated select bits (aliases when M is not a power of 2). No local responses are generated; the err bit is tied to 0.

## Test plan
- AR addr 0x1000_0000, SEL_LSB=28, M=2: bus AR valid 1 cycle after the handshake, Dst=1, Src=PORT_IDX; holds 3 cycles under busARRdy_i=0.
- W beat offered before AW: wready=0 until the AW is accepted. 4-beat burst to dst 0: busWDst_o=0 on all beats; queue pops after the last beat.
- Fill the queue with 4 AWs and no W: the 5th AW sees awready=0. One full W burst frees one slot.
- R/B pass-through: busRVld_i with rid=3 and s_axi_rready=0 -> busRRdy_o=0; data is visible on s_axi_r the same cycle.
- DECERR_RESP_EN, M=3, AR addr 0x3000_0000, arlen=2: 3 local beats with rresp=2'b11, the last with rlast; no bus AR. AW to the same address plus a 2-beat W -> bresp=2'b11, no bus W.
- Assert rst during a 4-beat W burst: all outputs return to their reset values next cycle and the queue is empty.
